// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, working-variable type, FSM states and round functions.
// Working variables are packed {a,b,c,d,e,f,g,h} with a in the top word.
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int RND_W  = 6;

    typedef logic [7:0][WORD_W-1:0] vars_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } state_t;

    localparam vars_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [WORD_W-1:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y,
                                             input logic [WORD_W-1:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y,
                                              input logic [WORD_W-1:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Word-wise mod-2^32 add used for the chaining-value update.
    function automatic vars_t add_vars(input vars_t x, input vars_t y);
        vars_t s;
        for (int i = 0; i < 8; i++) s[i] = x[i] + y[i];
        return s;
    endfunction

endpackage

// File: rtl/sha256_compressor_if.sv
// Block-start / Wt input and digest output bundle of the SHA-256 compressor.
// master drives start/first/Wt (scheduler side); slave is the compressor.
interface sha256_compressor_if;
    import sha256_pkg::*;

    logic                start_i;
    logic                first_i;
    logic [WORD_W-1:0]   wt_i;
    logic                ready_o;
    logic [RND_W-1:0]    round_o;
    logic                done_o;
    logic [8*WORD_W-1:0] digest_o;

    modport master (
        output start_i, first_i, wt_i,
        input  ready_o, round_o, done_o, digest_o
    );

    modport slave (
        input  start_i, first_i, wt_i,
        output ready_o, round_o, done_o, digest_o
    );
endinterface

// File: rtl/sha256_round.sv
// One FIPS 180-4 compression round, purely combinational.
// Latency: zero cycles; no flow control.
module sha256_round
    import sha256_pkg::*;
(
    input  vars_t             i_vars,
    input  logic [WORD_W-1:0] i_k,
    input  logic [WORD_W-1:0] i_w,
    output vars_t             o_vars
);
    logic [WORD_W-1:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [WORD_W-1:0] w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_vars;

    assign w_t1 = w_h + bsig1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
    assign w_t2 = bsig0(w_a) + maj(w_a, w_b, w_c);

    assign o_vars = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
endmodule

// File: rtl/sha256_compressor.sv
// SHA-256 compression of one 512-bit block per 66 cycles, Wt streamed one word per round.
// Start accepted only in IDLE (ready_o); done_o pulses with the new digest one cycle after FINAL.
module sha256_compressor
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64,
    parameter int WORD_W     = 32
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    sha256_compressor_if.slave  bus
);
    localparam int                CNT_W = $clog2(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_ROUNDS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    vars_t              r_vars;
    vars_t              r_h;
    vars_t              r_digest;
    logic               r_done;

    logic               w_accept;
    logic [CNT_W-1:0]   w_round;
    logic [WORD_W-1:0]  w_k;
    vars_t              w_vars_nxt;
    vars_t              w_h_sum;

    assign w_k     = K[r_cnt];
    assign w_h_sum = add_vars(r_h, r_vars);

    sha256_round u_round (
        .i_vars (r_vars),
        .i_k    (w_k),
        .i_w    (bus.wt_i),
        .o_vars (w_vars_nxt)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_round     = '0;
        case (r_state)
            IDLE: begin
                w_accept = bus.start_i;
                if (bus.start_i) w_state_nxt = ROUND;
            end
            ROUND: begin
                w_round = r_cnt;
                if (r_cnt == LAST) w_state_nxt = FINAL;
            end
            FINAL: begin
                w_round     = LAST;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The digest has its own register so an IV reload on the next accept
    // does not disturb the presented result before the next done_o.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt    <= '0;
            r_vars   <= '0;
            r_h      <= '0;
            r_digest <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == FINAL);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_vars <= bus.first_i ? IV : r_h;
                        if (bus.first_i) r_h <= IV;
                        r_cnt <= '0;
                    end
                end
                ROUND: begin
                    r_vars <= w_vars_nxt;
                    if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
                end
                FINAL: begin
                    r_h      <= w_h_sum;
                    r_digest <= w_h_sum;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o  = (r_state == IDLE);
    assign bus.round_o  = w_round;
    assign bus.done_o   = r_done;
    assign bus.digest_o = r_digest;
endmodule
